// File: rtl/regfile_sb_if.sv
// Register-file access bundle: write port, reserve port, NRD read ports, ready status.
// AW must equal $clog2(NREGS) of the attached regfile_sb.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
);
  logic                enable_i;
  logic                reg_write_i;
  logic [AW-1:0]       rd_i;
  logic [XLEN-1:0]     write_data_i;
  logic                reserve_i;
  logic [AW-1:0]       reserve_rd_i;
  logic [NRD*AW-1:0]   rs_i;
  logic [NRD*XLEN-1:0] rs_data_o;
  logic [NRD-1:0]      rs_busy_o;
  logic                ready_o;

  modport master (
    output enable_i, reg_write_i, rd_i, write_data_i, reserve_i, reserve_rd_i, rs_i,
    input  rs_data_o, rs_busy_o, ready_o
  );

  modport slave (
    input  enable_i, reg_write_i, rd_i, write_data_i, reserve_i, reserve_rd_i, rs_i,
    output rs_data_o, rs_busy_o, ready_o
  );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised RV32I integer register file with busy scoreboard, optional x0 hardwiring,
// optional write-to-read bypass and a one-entry-per-cycle clear sweep after reset.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST    = AW'(NREGS-1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          r_state;
  logic            r_ready;
  logic [AW-1:0]   r_cnt;
  logic [NREGS-1:0] r_busy;
  logic [XLEN-1:0] r_mem [NREGS];

  logic            w_wq, w_rq, w_mem_we;
  logic [AW-1:0]   w_mem_addr;
  logic [XLEN-1:0] w_mem_data;

  // In range and not the hardwired zero register.
  function automatic logic f_valid(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_W) && !(ZERO_REG && (a == '0));
  endfunction

  assign w_wq = (r_state == S_RUN) && bus.enable_i && bus.reg_write_i && f_valid(bus.rd_i);
  assign w_rq = (r_state == S_RUN) && bus.enable_i && bus.reserve_i && f_valid(bus.reserve_rd_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_INIT;
      r_ready <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= S_RUN;
            r_ready <= 1'b1;
          end
        end
        S_RUN: begin
          // Reserve is applied last so it wins over a same-register write.
          if (w_wq) r_busy[bus.rd_i] <= 1'b0;
          if (w_rq) r_busy[bus.reserve_rd_i] <= 1'b1;
        end
        default: begin
          r_state <= S_INIT;
          r_ready <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Single write port shared by the clear sweep and normal writes; no reset so it maps to RAM.
  assign w_mem_we   = !rst_i && ((r_state == S_INIT) || w_wq);
  assign w_mem_addr = (r_state == S_INIT) ? r_cnt : bus.rd_i;
  assign w_mem_data = (r_state == S_INIT) ? '0 : bus.write_data_i;

  always_ff @(posedge clk_i) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   w_rs;
    logic [XLEN-1:0] w_data;
    logic            w_busy;

    assign w_rs = bus.rs_i[k*AW +: AW];

    always_comb begin
      w_data = '0;
      w_busy = 1'b0;
      if (r_ready && f_valid(w_rs)) begin
        if (BYPASS && w_wq && (bus.rd_i == w_rs)) begin
          w_data = bus.write_data_i;
        end else begin
          w_data = r_mem[w_rs];
          w_busy = r_busy[w_rs];
        end
      end
    end

    assign bus.rs_data_o[k*XLEN +: XLEN] = w_data;
    assign bus.rs_busy_o[k]              = w_busy;
  end

  assign bus.ready_o = r_ready;
endmodule
